triangle_setup: RTL and testbench

//   Triangle setup stage, directly upstream of the rasterizer. Accepts one screen-space

---
 rtl/triangle_setup.sv | 163 ++++++++++++++++
 tb/tb_triangle_setup.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/triangle_setup.sv
// Triangle setup: edge-function coefficients and doubled signed area from one shared
// multiplier, with degenerate/back-face culling ahead of the rasterizer.
module triangle_setup #(
  parameter int COORD_W       = 10,
  parameter bit CULL_BACKFACE = 1'b1,
  parameter int CNT_W         = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [COORD_W-1:0]   in_x0,
  input  logic [COORD_W-1:0]   in_y0,
  input  logic [COORD_W-1:0]   in_x1,
  input  logic [COORD_W-1:0]   in_y1,
  input  logic [COORD_W-1:0]   in_x2,
  input  logic [COORD_W-1:0]   in_y2,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [COORD_W-1:0]   out_x0,
  output logic [COORD_W-1:0]   out_y0,
  output logic [COORD_W-1:0]   out_x1,
  output logic [COORD_W-1:0]   out_y1,
  output logic [COORD_W-1:0]   out_x2,
  output logic [COORD_W-1:0]   out_y2,
  output logic [COORD_W:0]     out_a0,
  output logic [COORD_W:0]     out_a1,
  output logic [COORD_W:0]     out_a2,
  output logic [COORD_W:0]     out_b0,
  output logic [COORD_W:0]     out_b1,
  output logic [COORD_W:0]     out_b2,
  output logic [2*COORD_W:0]   out_c0,
  output logic [2*COORD_W:0]   out_c1,
  output logic [2*COORD_W:0]   out_c2,
  output logic [2*COORD_W+2:0] out_area,
  output logic [CNT_W-1:0]     cull_count,
  output logic                 busy
);

  localparam int PW = 2 * COORD_W;
  localparam int CW = 2 * COORD_W + 1;
  localparam int RW = 2 * COORD_W + 3;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_DIFF  = 3'd1,
    S_MUL   = 3'd2,
    S_AREA  = 3'd3,
    S_CHECK = 3'd4,
    S_OUT   = 3'd5
  } state_t;

  state_t            state;
  state_t            next_state;
  logic [2:0]        step;
  logic [COORD_W-1:0] mul_a;
  logic [COORD_W-1:0] mul_b;
  logic [PW-1:0]     prod;
  logic [PW-1:0]     prod_hold;
  logic              cull_now;

  assign cull_now = (out_area == {RW{1'b0}}) || (out_area[RW-1] && CULL_BACKFACE);
  assign prod     = {{COORD_W{1'b0}}, mul_a} * {{COORD_W{1'b0}}, mul_b};

  // Operand select for the shared multiplier; even steps hold, odd steps finish C_i.
  always_comb begin
    mul_a = out_x1;
    mul_b = out_y2;
    case (step)
      3'd0:    begin mul_a = out_x1; mul_b = out_y2; end
      3'd1:    begin mul_a = out_x2; mul_b = out_y1; end
      3'd2:    begin mul_a = out_x2; mul_b = out_y0; end
      3'd3:    begin mul_a = out_x0; mul_b = out_y2; end
      3'd4:    begin mul_a = out_x0; mul_b = out_y1; end
      3'd5:    begin mul_a = out_x1; mul_b = out_y0; end
      default: begin mul_a = out_x1; mul_b = out_y2; end
    endcase
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (in_valid && in_ready) next_state = S_DIFF; else next_state = S_IDLE;
      S_DIFF:  next_state = S_MUL;
      S_MUL:   if (step == 3'd5) next_state = S_AREA; else next_state = S_MUL;
      S_AREA:  next_state = S_CHECK;
      S_CHECK: if (cull_now) next_state = S_IDLE; else next_state = S_OUT;
      S_OUT:   if (out_ready) next_state = S_OUT == state ? S_IDLE : S_OUT; else next_state = S_OUT;
      default: next_state = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  // Handshake flags and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_ready <= 1'b0;  busy <= 1'b0;  out_valid <= 1'b0;
      step <= 3'd0;  prod_hold <= {PW{1'b0}};  cull_count <= {CNT_W{1'b0}};
      out_x0 <= {COORD_W{1'b0}};  out_y0 <= {COORD_W{1'b0}};
      out_x1 <= {COORD_W{1'b0}};  out_y1 <= {COORD_W{1'b0}};
      out_x2 <= {COORD_W{1'b0}};  out_y2 <= {COORD_W{1'b0}};
      out_a0 <= {(COORD_W+1){1'b0}};  out_a1 <= {(COORD_W+1){1'b0}};  out_a2 <= {(COORD_W+1){1'b0}};
      out_b0 <= {(COORD_W+1){1'b0}};  out_b1 <= {(COORD_W+1){1'b0}};  out_b2 <= {(COORD_W+1){1'b0}};
      out_c0 <= {CW{1'b0}};  out_c1 <= {CW{1'b0}};  out_c2 <= {CW{1'b0}};
      out_area <= {RW{1'b0}};
    end else begin
      in_ready  <= (next_state == S_IDLE);
      busy      <= (next_state != S_IDLE);
      out_valid <= (next_state == S_OUT);
      case (state)
        S_IDLE: begin
          step <= 3'd0;
          if (in_valid && in_ready) begin
            out_x0 <= in_x0;  out_y0 <= in_y0;
            out_x1 <= in_x1;  out_y1 <= in_y1;
            out_x2 <= in_x2;  out_y2 <= in_y2;
          end
        end
        S_DIFF: begin
          out_a0 <= {1'b0, out_y1} - {1'b0, out_y2};
          out_a1 <= {1'b0, out_y2} - {1'b0, out_y0};
          out_a2 <= {1'b0, out_y0} - {1'b0, out_y1};
          out_b0 <= {1'b0, out_x2} - {1'b0, out_x1};
          out_b1 <= {1'b0, out_x0} - {1'b0, out_x2};
          out_b2 <= {1'b0, out_x1} - {1'b0, out_x0};
        end
        S_MUL: begin
          step <= step + 3'd1;
          case (step)
            3'd1:    out_c0 <= {1'b0, prod_hold} - {1'b0, prod};
            3'd3:    out_c1 <= {1'b0, prod_hold} - {1'b0, prod};
            3'd5:    out_c2 <= {1'b0, prod_hold} - {1'b0, prod};
            default: prod_hold <= prod;
          endcase
        end
        S_AREA: begin
          out_area <= {{2{out_c0[CW-1]}}, out_c0} + {{2{out_c1[CW-1]}}, out_c1}
                    + {{2{out_c2[CW-1]}}, out_c2};
        end
        S_CHECK: begin
          if (cull_now) begin
            if (cull_count != {CNT_W{1'b1}}) cull_count <= cull_count + {{(CNT_W-1){1'b0}}, 1'b1};
          end else if (out_area[RW-1]) begin
            // Clockwise triangle kept: flip orientation so area is positive downstream.
            out_a0 <= -out_a0;  out_a1 <= -out_a1;  out_a2 <= -out_a2;
            out_b0 <= -out_b0;  out_b1 <= -out_b1;  out_b2 <= -out_b2;
            out_c0 <= -out_c0;  out_c1 <= -out_c1;  out_c2 <= -out_c2;
            out_area <= -out_area;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_triangle_setup.sv
// Bench for triangle_setup: two instances (back-face culling on, and off with a
// narrow cull counter) checked against a reference model through per-instance queues.
module tb_triangle_setup;

  typedef struct {
    int     x[3];
    int     y[3];
    longint a[3];
    longint b[3];
    longint c[3];
    longint area;
    bit     culled;
    int     acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic out_ready = 1'b1;
  logic [9:0] in_x0 = 10'd0, in_y0 = 10'd0, in_x1 = 10'd0, in_y1 = 10'd0, in_x2 = 10'd0, in_y2 = 10'd0;

  logic              in_ready_a, out_valid_a, busy_a;
  logic [9:0]        ox_a[3], oy_a[3];
  logic signed [10:0] oa_a[3], ob_a[3];
  logic signed [20:0] oc_a[3];
  logic signed [22:0] oarea_a;
  logic [15:0]       cc_a;

  logic              in_ready_b, out_valid_b, busy_b;
  logic [9:0]        ox_b[3], oy_b[3];
  logic signed [10:0] oa_b[3], ob_b[3];
  logic signed [20:0] oc_b[3];
  logic signed [22:0] oarea_b;
  logic [1:0]        cc_b;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   ecnt_a  = 0;
  int   ecnt_b  = 0;
  bit   pv_a    = 1'b0;
  bit   pv_b    = 1'b0;
  exp_t q_a[$];
  exp_t q_b[$];

  triangle_setup dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_x0(in_x0), .in_y0(in_y0), .in_x1(in_x1), .in_y1(in_y1), .in_x2(in_x2), .in_y2(in_y2),
    .out_valid(out_valid_a), .out_ready(out_ready),
    .out_x0(ox_a[0]), .out_y0(oy_a[0]), .out_x1(ox_a[1]), .out_y1(oy_a[1]),
    .out_x2(ox_a[2]), .out_y2(oy_a[2]),
    .out_a0(oa_a[0]), .out_a1(oa_a[1]), .out_a2(oa_a[2]),
    .out_b0(ob_a[0]), .out_b1(ob_a[1]), .out_b2(ob_a[2]),
    .out_c0(oc_a[0]), .out_c1(oc_a[1]), .out_c2(oc_a[2]),
    .out_area(oarea_a), .cull_count(cc_a), .busy(busy_a)
  );

  triangle_setup #(.COORD_W(10), .CULL_BACKFACE(1'b0), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_x0(in_x0), .in_y0(in_y0), .in_x1(in_x1), .in_y1(in_y1), .in_x2(in_x2), .in_y2(in_y2),
    .out_valid(out_valid_b), .out_ready(out_ready),
    .out_x0(ox_b[0]), .out_y0(oy_b[0]), .out_x1(ox_b[1]), .out_y1(oy_b[1]),
    .out_x2(ox_b[2]), .out_y2(oy_b[2]),
    .out_a0(oa_b[0]), .out_a1(oa_b[1]), .out_a2(oa_b[2]),
    .out_b0(ob_b[0]), .out_b1(ob_b[1]), .out_b2(ob_b[2]),
    .out_c0(oc_b[0]), .out_c1(oc_b[1]), .out_c2(oc_b[2]),
    .out_area(oarea_b), .cull_count(cc_b), .busy(busy_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string tag, longint got, longint exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic exp_t model(int x0, int y0, int x1, int y1, int x2, int y2, bit cbf);
    exp_t e;
    int i, j;
    e.x = '{x0, x1, x2};
    e.y = '{y0, y1, y2};
    e.area = 0;
    e.acc = 0;
    for (int k = 0; k < 3; k++) begin
      i = (k + 1) % 3;
      j = (k + 2) % 3;
      e.a[k] = e.y[i] - e.y[j];
      e.b[k] = e.x[j] - e.x[i];
      e.c[k] = longint'(e.x[i]) * e.y[j] - longint'(e.x[j]) * e.y[i];
      e.area += e.c[k];
    end
    e.culled = (e.area == 0) || (e.area < 0 && cbf);
    if (!e.culled && e.area < 0) begin
      for (int k = 0; k < 3; k++) begin
        e.a[k] = -e.a[k];  e.b[k] = -e.b[k];  e.c[k] = -e.c[k];
      end
      e.area = -e.area;
    end
    return e;
  endfunction

  function automatic exp_t obs_a();
    exp_t e;
    for (int k = 0; k < 3; k++) begin
      e.x[k] = ox_a[k];  e.y[k] = oy_a[k];
      e.a[k] = oa_a[k];  e.b[k] = ob_a[k];  e.c[k] = oc_a[k];
    end
    e.area = oarea_a;  e.culled = 1'b0;  e.acc = 0;
    return e;
  endfunction

  function automatic exp_t obs_b();
    exp_t e;
    for (int k = 0; k < 3; k++) begin
      e.x[k] = ox_b[k];  e.y[k] = oy_b[k];
      e.a[k] = oa_b[k];  e.b[k] = ob_b[k];  e.c[k] = oc_b[k];
    end
    e.area = oarea_b;  e.culled = 1'b0;  e.acc = 0;
    return e;
  endfunction

  task automatic cmp(string p, exp_t g, exp_t e);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("%s_x%0d", p, k), g.x[k], e.x[k]);
      chk($sformatf("%s_y%0d", p, k), g.y[k], e.y[k]);
      chk($sformatf("%s_a%0d", p, k), g.a[k], e.a[k]);
      chk($sformatf("%s_b%0d", p, k), g.b[k], e.b[k]);
      chk($sformatf("%s_c%0d", p, k), g.c[k], e.c[k]);
    end
    chk({p, "_area"}, g.area, e.area);
  endtask

  // Output monitors: latency on first valid cycle, full compare on handshake.
  always @(negedge clk) begin
    if (!rst && out_valid_a) begin
      if (!pv_a) begin
        if (q_a.size() == 0) chk("unexpected_out_a", 1, 0);
        else chk("latency_a", cyc - q_a[0].acc, 9);
      end
      if (out_ready && q_a.size() > 0) begin
        cmp("out_a", obs_a(), q_a[0]);
        void'(q_a.pop_front());
      end
    end
    pv_a <= out_valid_a;
  end

  always @(negedge clk) begin
    if (!rst && out_valid_b) begin
      if (!pv_b) begin
        if (q_b.size() == 0) chk("unexpected_out_b", 1, 0);
        else chk("latency_b", cyc - q_b[0].acc, 9);
      end
      if (out_ready && q_b.size() > 0) begin
        cmp("out_b", obs_b(), q_b[0]);
        void'(q_b.pop_front());
      end
    end
    pv_b <= out_valid_b;
  end

  task automatic send(int x0, int y0, int x1, int y1, int x2, int y2);
    exp_t ea, eb;
    int n = 0;
    ea = model(x0, y0, x1, y1, x2, y2, 1'b1);
    eb = model(x0, y0, x1, y1, x2, y2, 1'b0);
    while (!(in_ready_a && in_ready_b) && n < 200) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 200) begin
      chk("ready_timeout", 1, 0);
      return;
    end
    in_valid = 1'b1;
    in_x0 = 10'(x0); in_y0 = 10'(y0); in_x1 = 10'(x1);
    in_y1 = 10'(y1); in_x2 = 10'(x2); in_y2 = 10'(y2);
    @(posedge clk); #1;
    in_valid = 1'b0;
    ea.acc = cyc;
    eb.acc = cyc;
    if (ea.culled) ecnt_a = (ecnt_a == 65535) ? 65535 : ecnt_a + 1;
    else q_a.push_back(ea);
    if (eb.culled) ecnt_b = (ecnt_b == 3) ? 3 : ecnt_b + 1;
    else q_b.push_back(eb);
  endtask

  task automatic drain();
    int n = 0;
    while ((q_a.size() != 0 || q_b.size() != 0 || busy_a || busy_b) && n < 300) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 300) chk("drain_timeout", 1, 0);
    chk("cull_count_a", cc_a, ecnt_a);
    chk("cull_count_b", cc_b, ecnt_b);
  endtask

  initial begin
    exp_t snap;
    int n;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready_a, 0);
    chk("rst_out_valid", out_valid_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_cull", cc_a, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_in_ready", in_ready_a, 1);

    send(0, 0, 10, 0, 0, 10);
    drain();
    chk("t1_area", oarea_a, 100);
    chk("t1_a0", oa_a[0], -10);

    send(0, 0, 0, 10, 10, 0);
    repeat (8) begin @(posedge clk); #1; end
    chk("cull_in_ready_t9", in_ready_a, 0);
    @(posedge clk); #1;
    chk("cull_in_ready_t10", in_ready_a, 1);
    drain();
    chk("t2_b_area", oarea_b, 100);

    repeat (5) send(0, 0, 5, 5, 10, 10);
    drain();

    send(1023, 0, 1023, 1023, 0, 0);
    drain();
    chk("t4_c2", oc_a[2], 1046529);
    chk("t4_area", oarea_a, 1046529);

    for (int r = 0; r < 6; r++)
      send($urandom_range(0, 1023), $urandom_range(0, 1023), $urandom_range(0, 1023),
           $urandom_range(0, 1023), $urandom_range(0, 1023), $urandom_range(0, 1023));
    drain();

    // Back-pressure: outputs frozen and new input ignored while stalled.
    out_ready = 1'b0;
    send(0, 0, 10, 0, 0, 10);
    n = 0;
    while (!out_valid_a && n < 50) begin @(posedge clk); #1; n++; end
    chk("stall_valid_seen", out_valid_a, 1);
    snap = obs_a();
    in_valid = 1'b1;
    in_x0 = 10'd7; in_y0 = 10'd3; in_x1 = 10'd200; in_y1 = 10'd9; in_x2 = 10'd50; in_y2 = 10'd300;
    repeat (5) begin
      @(posedge clk); #1;
      cmp("stall", obs_a(), snap);
      chk("stall_in_ready", in_ready_a, 0);
      chk("stall_out_valid", out_valid_a, 1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("xfer_valid_drop", out_valid_a, 0);
    chk("xfer_idle", in_ready_a, 1);
    drain();

    // Reset mid-flight.
    send(1023, 0, 1023, 1023, 0, 0);
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    chk("midrst_busy", busy_a, 0);
    chk("midrst_in_ready", in_ready_a, 0);
    chk("midrst_cull", cc_a, 0);
    chk("midrst_x0", ox_a[0], 0);
    chk("midrst_c0", oc_a[0], 0);
    chk("midrst_area", oarea_a, 0);
    q_a.delete();
    q_b.delete();
    ecnt_a = 0;
    ecnt_b = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rel_in_ready", in_ready_a, 0);
    @(posedge clk); #1;
    chk("rel_in_ready_next", in_ready_a, 1);
    send(3, 1, 40, 2, 9, 30);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
